// File: rtl/pipeline_pkg.sv
// Shared definitions for the decode stage: instruction field positions, opcodes,
// default widths and the decode FSM state encoding.
package pipeline_pkg;

    localparam int PC_W_DEF   = 7;
    localparam int DATA_W_DEF = 32;
    localparam int NREG_DEF   = 32;

    localparam int OPC_HI   = 31;
    localparam int OPC_LO   = 26;
    localparam int RS_HI    = 25;
    localparam int RS_LO    = 21;
    localparam int RT_HI    = 20;
    localparam int RT_LO    = 16;
    localparam int RD_HI    = 15;
    localparam int RD_LO    = 11;
    localparam int IMM_HI   = 15;
    localparam int IMM_LO   = 0;
    localparam int FUNCT_HI = 5;
    localparam int FUNCT_LO = 0;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_STALL  = 2'd1,
        ST_SQUASH = 2'd2
    } dec_state_t;

    // Opcodes whose rt field is a source operand (and so can hit a load-use hazard).
    function automatic logic uses_rt(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_BEQ) || (op == OP_BNE) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/register_file.sv
// Two-read, one-write register file with write-first bypass; r0 always reads zero.
module register_file
    import pipeline_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int NREG   = NREG_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [4:0]        i_rd_addr_a,
    input  logic [4:0]        i_rd_addr_b,
    output logic [DATA_W-1:0] o_rd_data_a,
    output logic [DATA_W-1:0] o_rd_data_b,
    input  logic              i_we,
    input  logic [4:0]        i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data
);

    logic [DATA_W-1:0] r_regs [NREG];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else if (i_we && (i_wr_addr != 5'd0)) begin
            r_regs[i_wr_addr] <= i_wr_data;
        end
    end

    always_comb begin
        o_rd_data_a = r_regs[i_rd_addr_a];
        o_rd_data_b = r_regs[i_rd_addr_b];
        if (i_rd_addr_a == 5'd0) begin
            o_rd_data_a = '0;
        end else if (i_we && (i_wr_addr == i_rd_addr_a)) begin
            o_rd_data_a = i_wr_data;
        end
        if (i_rd_addr_b == 5'd0) begin
            o_rd_data_b = '0;
        end else if (i_we && (i_wr_addr == i_rd_addr_b)) begin
            o_rd_data_b = i_wr_data;
        end
    end

endmodule

// File: rtl/decode_stage.sv
// Instruction decode stage: register read, control decode, branch resolution,
// load-use stall and the registered ID/EX latch.
module decode_stage
    import pipeline_pkg::*;
#(
    parameter int PC_W   = PC_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int NREG   = NREG_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [PC_W-1:0]   if_pc,
    input  logic [DATA_W-1:0] if_instr,
    input  logic              if_bubble,
    input  logic              wb_we,
    input  logic [4:0]        wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              fetch_enbl,
    output logic              dec,
    output logic [PC_W-1:0]   pc_mux,
    output logic              id_valid,
    output logic [PC_W-1:0]   id_pc,
    output logic [5:0]        id_opcode,
    output logic [5:0]        id_funct,
    output logic [DATA_W-1:0] id_rs_val,
    output logic [DATA_W-1:0] id_rt_val,
    output logic [DATA_W-1:0] id_imm,
    output logic [4:0]        id_dest,
    output logic              id_reg_write,
    output logic              id_is_load
);

    dec_state_t r_state, w_next_state;

    logic [DATA_W-1:0] r_hold_instr;
    logic [PC_W-1:0]   r_hold_pc;

    logic              r_dec;
    logic [PC_W-1:0]   r_pc_mux;
    logic              r_id_valid;
    logic [PC_W-1:0]   r_id_pc;
    logic [5:0]        r_id_opcode;
    logic [5:0]        r_id_funct;
    logic [DATA_W-1:0] r_id_rs_val;
    logic [DATA_W-1:0] r_id_rt_val;
    logic [DATA_W-1:0] r_id_imm;
    logic [4:0]        r_id_dest;
    logic              r_id_reg_write;
    logic              r_id_is_load;

    logic [DATA_W-1:0] w_instr;
    logic [PC_W-1:0]   w_pc;
    logic              w_valid;
    logic [5:0]        w_op;
    logic [4:0]        w_rs;
    logic [4:0]        w_rt;
    logic [4:0]        w_rd;
    logic [DATA_W-1:0] w_imm;
    logic [DATA_W-1:0] w_rs_val;
    logic [DATA_W-1:0] w_rt_val;
    logic [4:0]        w_dest;
    logic              w_reg_write;
    logic              w_hazard;
    logic              w_taken;
    logic [PC_W-1:0]   w_target;

    // Pick the active instruction: the held copy in STALL, nothing in SQUASH.
    always_comb begin
        w_instr = if_instr;
        w_pc    = if_pc;
        w_valid = 1'b0;
        case (r_state)
            ST_RUN: begin
                w_valid = ~if_bubble;
            end
            ST_STALL: begin
                w_instr = r_hold_instr;
                w_pc    = r_hold_pc;
                w_valid = 1'b1;
            end
            default: begin
                w_valid = 1'b0;
            end
        endcase
    end

    assign w_op  = w_instr[OPC_HI:OPC_LO];
    assign w_rs  = w_instr[RS_HI:RS_LO];
    assign w_rt  = w_instr[RT_HI:RT_LO];
    assign w_rd  = w_instr[RD_HI:RD_LO];
    assign w_imm = {{(DATA_W-16){w_instr[IMM_HI]}}, w_instr[IMM_HI:IMM_LO]};

    register_file #(
        .DATA_W (DATA_W),
        .NREG   (NREG)
    ) u_regfile (
        .clk         (clk),
        .rst         (rst),
        .i_rd_addr_a (w_rs),
        .i_rd_addr_b (w_rt),
        .o_rd_data_a (w_rs_val),
        .o_rd_data_b (w_rt_val),
        .i_we        (wb_we),
        .i_wr_addr   (wb_addr),
        .i_wr_data   (wb_data)
    );

    always_comb begin
        w_dest = 5'd0;
        case (w_op)
            OP_RTYPE:      w_dest = w_rd;
            OP_ADDI, OP_LW: w_dest = w_rt;
            default:       w_dest = 5'd0;
        endcase
        w_reg_write = ((w_op == OP_RTYPE) || (w_op == OP_ADDI) || (w_op == OP_LW))
                      && (w_dest != 5'd0);
    end

    // A bubble sits in ID/EX during STALL, so the hazard can only fire from RUN.
    assign w_hazard = w_valid && r_id_valid && r_id_is_load && (r_id_dest != 5'd0)
                      && ((r_id_dest == w_rs) || (uses_rt(w_op) && (r_id_dest == w_rt)));

    assign w_taken = w_valid && !w_hazard
                     && ((w_op == OP_J)
                         || ((w_op == OP_BEQ) && (w_rs_val == w_rt_val))
                         || ((w_op == OP_BNE) && (w_rs_val != w_rt_val)));

    assign w_target = (w_op == OP_J) ? w_instr[PC_W-1:0]
                                     : w_pc + PC_W'(1) + w_instr[PC_W-1:0];

    assign fetch_enbl = rst || !w_hazard;

    always_comb begin
        w_next_state = ST_RUN;
        if (w_hazard) begin
            w_next_state = ST_STALL;
        end else if (w_taken) begin
            w_next_state = ST_SQUASH;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= ST_RUN;
            r_hold_instr   <= '0;
            r_hold_pc      <= '0;
            r_dec          <= 1'b0;
            r_pc_mux       <= '0;
            r_id_valid     <= 1'b0;
            r_id_pc        <= '0;
            r_id_opcode    <= '0;
            r_id_funct     <= '0;
            r_id_rs_val    <= '0;
            r_id_rt_val    <= '0;
            r_id_imm       <= '0;
            r_id_dest      <= '0;
            r_id_reg_write <= 1'b0;
            r_id_is_load   <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_dec   <= w_taken;
            if (w_taken) begin
                r_pc_mux <= w_target;
            end
            if (w_hazard) begin
                r_hold_instr <= w_instr;
                r_hold_pc    <= w_pc;
            end
            if (w_valid && !w_hazard) begin
                r_id_valid     <= 1'b1;
                r_id_pc        <= w_pc;
                r_id_opcode    <= w_op;
                r_id_funct     <= w_instr[FUNCT_HI:FUNCT_LO];
                r_id_rs_val    <= w_rs_val;
                r_id_rt_val    <= w_rt_val;
                r_id_imm       <= w_imm;
                r_id_dest      <= w_dest;
                r_id_reg_write <= w_reg_write;
                r_id_is_load   <= (w_op == OP_LW);
            end else begin
                r_id_valid     <= 1'b0;
                r_id_pc        <= '0;
                r_id_opcode    <= '0;
                r_id_funct     <= '0;
                r_id_rs_val    <= '0;
                r_id_rt_val    <= '0;
                r_id_imm       <= '0;
                r_id_dest      <= '0;
                r_id_reg_write <= 1'b0;
                r_id_is_load   <= 1'b0;
            end
        end
    end

    assign dec          = r_dec;
    assign pc_mux       = r_pc_mux;
    assign id_valid     = r_id_valid;
    assign id_pc        = r_id_pc;
    assign id_opcode    = r_id_opcode;
    assign id_funct     = r_id_funct;
    assign id_rs_val    = r_id_rs_val;
    assign id_rt_val    = r_id_rt_val;
    assign id_imm       = r_id_imm;
    assign id_dest      = r_id_dest;
    assign id_reg_write = r_id_reg_write;
    assign id_is_load   = r_id_is_load;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed scenarios with literal expectations,
// then randomized traffic checked against a behavioural model every cycle.
module tb_decode_stage;

    localparam int PC_W   = 7;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic [PC_W-1:0]   if_pc;
    logic [DATA_W-1:0] if_instr;
    logic              if_bubble;
    logic              wb_we;
    logic [4:0]        wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic              fetch_enbl;
    logic              dec;
    logic [PC_W-1:0]   pc_mux;
    logic              id_valid;
    logic [PC_W-1:0]   id_pc;
    logic [5:0]        id_opcode;
    logic [5:0]        id_funct;
    logic [DATA_W-1:0] id_rs_val;
    logic [DATA_W-1:0] id_rt_val;
    logic [DATA_W-1:0] id_imm;
    logic [4:0]        id_dest;
    logic              id_reg_write;
    logic              id_is_load;

    always #5 clk = ~clk;

    decode_stage #(.PC_W(PC_W), .DATA_W(DATA_W), .NREG(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .if_pc        (if_pc),
        .if_instr     (if_instr),
        .if_bubble    (if_bubble),
        .wb_we        (wb_we),
        .wb_addr      (wb_addr),
        .wb_data      (wb_data),
        .fetch_enbl   (fetch_enbl),
        .dec          (dec),
        .pc_mux       (pc_mux),
        .id_valid     (id_valid),
        .id_pc        (id_pc),
        .id_opcode    (id_opcode),
        .id_funct     (id_funct),
        .id_rs_val    (id_rs_val),
        .id_rt_val    (id_rt_val),
        .id_imm       (id_imm),
        .id_dest      (id_dest),
        .id_reg_write (id_reg_write),
        .id_is_load   (id_is_load)
    );

    typedef struct {
        bit        valid;
        bit [6:0]  pc;
        bit [5:0]  opcode;
        bit [5:0]  funct;
        bit [31:0] rsVal;
        bit [31:0] rtVal;
        bit [31:0] imm;
        bit [4:0]  dest;
        bit        regWrite;
        bit        isLoad;
    } idexT;

    // Model state: architectural registers, ID/EX contents, held instruction, squash flag.
    bit [31:0] mRegs [32];
    idexT      mId, nId;
    bit        mDec, nDec;
    bit [6:0]  mPcMux, nPcMux;
    bit        mHeld, nHeld;
    bit [31:0] mHeldInstr, nHeldInstr;
    bit [6:0]  mHeldPc, nHeldPc;
    bit        mSquash, nSquash;
    bit        expFetch;
    bit        lastFetch;

    int nCompared   = 0;
    int nMismatched = 0;

    function automatic bit [31:0] mkI(bit [5:0] op, bit [4:0] rs, bit [4:0] rt, bit [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic bit [31:0] mkR(bit [4:0] rs, bit [4:0] rt, bit [4:0] rd, bit [5:0] funct);
        return {6'h00, rs, rt, rd, 5'd0, funct};
    endfunction

    function automatic bit [31:0] mRead(bit [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (wb_we && wb_addr == a) return wb_data;
        return mRegs[a];
    endfunction

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: got 0x%0h, wanted 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Work out what the stage must do this cycle from the current inputs.
    task automatic modelEval();
        bit [31:0] instr;
        bit [6:0]  pc;
        bit        valid;
        bit [5:0]  op;
        bit [4:0]  rs, rt, rd;
        bit        usesRt, hazard, taken;
        idexT      e;
        e = '{default: 0};
        nDec = 0; nPcMux = mPcMux; nHeld = 0; nHeldInstr = mHeldInstr; nHeldPc = mHeldPc;
        nSquash = 0; expFetch = 1;
        if (rst) begin
            nPcMux = 0;
        end else begin
            if (mHeld) begin
                instr = mHeldInstr; pc = mHeldPc; valid = 1;
            end else begin
                instr = if_instr; pc = if_pc; valid = !mSquash && !if_bubble;
            end
            op = instr[31:26]; rs = instr[25:21]; rt = instr[20:16]; rd = instr[15:11];
            usesRt = (op == 6'h00) || (op == 6'h04) || (op == 6'h05) || (op == 6'h2B);
            hazard = valid && mId.valid && mId.isLoad && mId.dest != 0
                     && (mId.dest == rs || (usesRt && mId.dest == rt));
            if (hazard) begin
                expFetch = 0; nHeld = 1; nHeldInstr = instr; nHeldPc = pc;
            end else if (valid) begin
                e.valid  = 1;
                e.pc     = pc;
                e.opcode = op;
                e.funct  = instr[5:0];
                e.rsVal  = mRead(rs);
                e.rtVal  = mRead(rt);
                e.imm    = {{16{instr[15]}}, instr[15:0]};
                if (op == 6'h00) e.dest = rd;
                else if (op == 6'h08 || op == 6'h23) e.dest = rt;
                e.regWrite = (op == 6'h00 || op == 6'h08 || op == 6'h23) && e.dest != 0;
                e.isLoad   = (op == 6'h23);
                taken = (op == 6'h02) || (op == 6'h04 && e.rsVal == e.rtVal)
                        || (op == 6'h05 && e.rsVal != e.rtVal);
                if (taken) begin
                    nDec = 1; nSquash = 1;
                    if (op == 6'h02) nPcMux = instr[6:0];
                    else nPcMux = 7'((int'(pc) + 1 + int'(instr[6:0])) % 128);
                end
            end
        end
        nId = e;
    endtask

    task automatic modelCommit();
        if (rst) begin
            for (int i = 0; i < 32; i++) mRegs[i] = 0;
        end else if (wb_we && wb_addr != 0) begin
            mRegs[wb_addr] = wb_data;
        end
        mId = nId; mDec = nDec; mPcMux = nPcMux; mHeld = nHeld;
        mHeldInstr = nHeldInstr; mHeldPc = nHeldPc; mSquash = nSquash;
    endtask

    task automatic checkOutput();
        checkVal("id_valid",     32'(id_valid),     32'(mId.valid));
        checkVal("id_pc",        32'(id_pc),        32'(mId.pc));
        checkVal("id_opcode",    32'(id_opcode),    32'(mId.opcode));
        checkVal("id_funct",     32'(id_funct),     32'(mId.funct));
        checkVal("id_rs_val",    id_rs_val,         mId.rsVal);
        checkVal("id_rt_val",    id_rt_val,         mId.rtVal);
        checkVal("id_imm",       id_imm,            mId.imm);
        checkVal("id_dest",      32'(id_dest),      32'(mId.dest));
        checkVal("id_reg_write", 32'(id_reg_write), 32'(mId.regWrite));
        checkVal("id_is_load",   32'(id_is_load),   32'(mId.isLoad));
        checkVal("dec",          32'(dec),          32'(mDec));
        checkVal("pc_mux",       32'(pc_mux),       32'(mPcMux));
    endtask

    // One clock: drive at the falling edge, check fetch_enbl, clock, check the latch.
    task automatic applyStimulus(input bit [31:0] instr, input bit [6:0] pc, input bit bubble,
                                 input bit we, input bit [4:0] waddr, input bit [31:0] wdata,
                                 input bit r);
        if_instr = instr; if_pc = pc; if_bubble = bubble;
        wb_we = we; wb_addr = waddr; wb_data = wdata; rst = r;
        #1;
        modelEval();
        lastFetch = fetch_enbl;
        checkVal("fetch_enbl", 32'(fetch_enbl), 32'(expFetch));
        @(posedge clk);
        modelCommit();
        @(negedge clk);
        checkOutput();
    endtask

    function automatic bit [31:0] randInstr();
        bit [4:0] rs, rt, rd;
        rs = 5'($urandom_range(0, 3));
        rt = 5'($urandom_range(0, 3));
        rd = 5'($urandom_range(0, 3));
        case ($urandom_range(0, 9))
            0: return mkR(rs, rt, rd, 6'($urandom_range(0, 63)));
            1: return {6'h02, 26'($urandom)};
            2: return mkI(6'h04, rs, rt, 16'($urandom));
            3: return mkI(6'h05, rs, rt, 16'($urandom));
            4: return mkI(6'h08, rs, rt, 16'($urandom));
            5, 6: return mkI(6'h23, rs, rt, 16'($urandom));
            7: return mkI(6'h2B, rs, rt, 16'($urandom));
            8: return 32'd0;
            default: return {6'h3F, 26'($urandom)};
        endcase
    endfunction

    initial begin
        // Reset
        applyStimulus(0, 0, 1, 0, 0, 0, 1);
        checkVal("rst_id_valid", 32'(id_valid), 32'd0);
        checkVal("rst_fetch_enbl", 32'(lastFetch), 32'd1);

        // ADDI r4,r3,7 after r3=5
        applyStimulus(0, 0, 1, 1, 5'd3, 32'd5, 0);
        applyStimulus(mkI(6'h08, 5'd3, 5'd4, 16'd7), 7'd2, 0, 0, 0, 0, 0);
        checkVal("t1_id_valid", 32'(id_valid), 32'd1);
        checkVal("t1_rs_val", id_rs_val, 32'd5);
        checkVal("t1_imm", id_imm, 32'd7);
        checkVal("t1_dest", 32'(id_dest), 32'd4);
        checkVal("t1_reg_write", 32'(id_reg_write), 32'd1);

        // Same-cycle bypass, and r0 stays zero
        applyStimulus(0, 0, 1, 1, 5'd1, 32'hAAAA, 0);
        applyStimulus(mkI(6'h08, 5'd1, 5'd6, 16'd0), 7'd3, 0, 1, 5'd1, 32'h1234, 0);
        checkVal("t2_bypass", id_rs_val, 32'h1234);
        applyStimulus(mkI(6'h08, 5'd0, 5'd7, 16'd0), 7'd4, 0, 1, 5'd0, 32'hFF, 0);
        checkVal("t2_r0", id_rs_val, 32'd0);

        // Load-use stall
        applyStimulus(mkI(6'h23, 5'd1, 5'd2, 16'd0), 7'd20, 0, 0, 0, 0, 0);
        applyStimulus(mkR(5'd2, 5'd3, 5'd5, 6'h20), 7'd21, 0, 0, 0, 0, 0);
        checkVal("t3_stall_fetch", 32'(lastFetch), 32'd0);
        checkVal("t3_bubble", 32'(id_valid), 32'd0);
        applyStimulus(mkR(5'd2, 5'd3, 5'd5, 6'h20), 7'd21, 0, 0, 0, 0, 0);
        checkVal("t3_resume_fetch", 32'(lastFetch), 32'd1);
        checkVal("t3_rtype_valid", 32'(id_valid), 32'd1);
        checkVal("t3_rtype_dest", 32'(id_dest), 32'd5);
        checkVal("t3_rtype_funct", 32'(id_funct), 32'h20);

        // Taken BEQ, squash, untaken BNE
        applyStimulus(mkI(6'h04, 5'd5, 5'd5, 16'd3), 7'd10, 0, 0, 0, 0, 0);
        checkVal("t4_dec", 32'(dec), 32'd1);
        checkVal("t4_pc_mux", 32'(pc_mux), 32'd14);
        applyStimulus(mkI(6'h08, 5'd1, 5'd1, 16'd1), 7'd11, 0, 0, 0, 0, 0);
        checkVal("t4_squash", 32'(id_valid), 32'd0);
        checkVal("t4_dec_drop", 32'(dec), 32'd0);
        applyStimulus(mkI(6'h05, 5'd5, 5'd5, 16'd3), 7'd12, 0, 0, 0, 0, 0);
        checkVal("t4_bne_dec", 32'(dec), 32'd0);

        // Jump target and PC wrap
        applyStimulus({6'h02, 26'h7F}, 7'd0, 0, 0, 0, 0, 0);
        checkVal("t5_j_target", 32'(pc_mux), 32'd127);
        applyStimulus(0, 7'd1, 1, 0, 0, 0, 0);
        applyStimulus(mkI(6'h04, 5'd0, 5'd0, 16'd5), 7'd126, 0, 0, 0, 0, 0);
        checkVal("t5_wrap", 32'(pc_mux), 32'd4);
        applyStimulus(0, 7'd127, 1, 0, 0, 0, 0);

        // Reset while stalled, then while squashing
        applyStimulus(mkI(6'h23, 5'd1, 5'd2, 16'd0), 7'd30, 0, 0, 0, 0, 0);
        applyStimulus(mkR(5'd2, 5'd2, 5'd6, 6'h21), 7'd31, 0, 0, 0, 0, 0);
        applyStimulus(mkR(5'd2, 5'd2, 5'd6, 6'h21), 7'd31, 0, 0, 0, 0, 1);
        checkVal("t6_stall_rst_valid", 32'(id_valid), 32'd0);
        applyStimulus(0, 7'd0, 1, 0, 0, 0, 0);
        checkVal("t6_held_dropped", 32'(id_valid), 32'd0);
        applyStimulus(mkI(6'h04, 5'd0, 5'd0, 16'd9), 7'd40, 0, 0, 0, 0, 0);
        applyStimulus(mkI(6'h08, 5'd1, 5'd1, 16'd1), 7'd41, 0, 0, 0, 0, 1);
        checkVal("t6_squash_rst_dec", 32'(dec), 32'd0);
        checkVal("t6_squash_rst_pc_mux", 32'(pc_mux), 32'd0);
        applyStimulus(0, 7'd0, 1, 0, 0, 0, 0);

        // Randomized traffic
        for (int n = 0; n < 800; n++) begin
            applyStimulus(randInstr(), 7'($urandom), ($urandom_range(0, 9) == 0),
                          $urandom_range(0, 1) == 1, 5'($urandom_range(0, 3)),
                          32'($urandom_range(0, 2)), ($urandom_range(0, 49) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
